// File: rtl/md_unit.sv
// Multiply/divide unit for the E stage: multi-cycle mult/multu/div/divu with HI/LO
// registers, plus direct HI/LO writes via mthi/mtlo.
module md_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        req,
    output logic        md_start,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CW = $clog2(MAX_CYCLES + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [63:0]   pending;
    logic          pending_ok;

    logic [63:0]   result;
    logic          result_ok;
    logic          is_mult;
    logic [63:0]   a_sext;
    logic [63:0]   b_sext;
    logic [31:0]   quot;
    logic [31:0]   rem;

    assign md_start = (md_op >= 3'd1) && (md_op <= 3'd4) && !req && !busy;

    always_comb begin
        result    = '0;
        result_ok = 1'b1;
        is_mult   = (md_op == 3'd1) || (md_op == 3'd2);
        a_sext    = {{32{rs_data[31]}}, rs_data};
        b_sext    = {{32{rt_data[31]}}, rt_data};
        quot      = '0;
        rem       = '0;
        case (md_op)
            3'd1: result = a_sext * b_sext;
            3'd2: result = {32'h0, rs_data} * {32'h0, rt_data};
            3'd3: begin
                if (rt_data == 32'h0) begin
                    result_ok = 1'b0;
                end else if (rs_data == 32'h8000_0000 && rt_data == 32'hFFFF_FFFF) begin
                    // Overflow case pinned explicitly rather than trusting the operator.
                    result = {32'h0, 32'h8000_0000};
                end else begin
                    quot   = 32'($signed(rs_data) / $signed(rt_data));
                    rem    = 32'($signed(rs_data) % $signed(rt_data));
                    result = {rem, quot};
                end
            end
            3'd4: begin
                if (rt_data == 32'h0) begin
                    result_ok = 1'b0;
                end else begin
                    quot   = rs_data / rt_data;
                    rem    = rs_data % rt_data;
                    result = {rem, quot};
                end
            end
            default: result = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            cnt        <= '0;
            pending    <= '0;
            pending_ok <= 1'b0;
            hi         <= '0;
            lo         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (md_start) begin
                        pending    <= result;
                        pending_ok <= result_ok;
                        cnt        <= is_mult ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                        busy       <= 1'b1;
                        state      <= RUN;
                    end else if (!req && md_op == 3'd5) begin
                        hi <= rs_data;
                    end else if (!req && md_op == 3'd6) begin
                        lo <= rs_data;
                    end
                end
                RUN: begin
                    if (cnt == CW'(1)) begin
                        if (pending_ok) begin
                            hi <= pending[63:32];
                            lo <= pending[31:0];
                        end
                        cnt   <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit: timing, arithmetic, mthi/mtlo, req and reset abort.
module tb_md_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  md_op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        req;
    logic        md_start;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .md_op    (md_op),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .req      (req),
        .md_start (md_start),
        .busy     (busy),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue op at edge T, confirm busy for n cycles with hi/lo frozen, then check commit.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int unsigned n,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        logic [31:0] old_hi;
        logic [31:0] old_lo;
        old_hi  = hi;
        old_lo  = lo;
        md_op   = op;
        rs_data = a;
        rt_data = b;
        #1;
        check({tag, " md_start"}, 32'(md_start), 32'd1);
        tick();
        md_op   = 3'd0;
        rs_data = 32'hDEAD_BEEF;
        rt_data = 32'hCAFE_F00D;
        for (int i = 0; i < int'(n); i++) begin
            check({tag, " busy"}, 32'(busy), 32'd1);
            check({tag, " hi held"}, hi, old_hi);
            check({tag, " lo held"}, lo, old_lo);
            tick();
        end
        check({tag, " busy done"}, 32'(busy), 32'd0);
        check({tag, " hi"}, hi, exp_hi);
        check({tag, " lo"}, lo, exp_lo);
    endtask

    initial begin
        reset   = 1'b0;
        md_op   = 3'd0;
        rs_data = '0;
        rt_data = '0;
        req     = 1'b0;
        tick();
        tick();
        check("reset hi", hi, 32'h0);
        check("reset lo", lo, 32'h0);
        check("reset busy", 32'(busy), 32'd0);
        reset = 1'b1;
        tick();

        run_op("mult", 3'd1, 32'hFFFF_FFFD, 32'd5, 5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run_op("multu", 3'd2, 32'hFFFF_FFFD, 32'd5, 5, 32'h0000_0004, 32'hFFFF_FFF1);
        run_op("div -7/2", 3'd3, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu 7/2", 3'd4, 32'd7, 32'd2, 10, 32'd1, 32'd3);
        run_op("div ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0, 32'h8000_0000);
        run_op("div 7/-2", 3'd3, 32'd7, 32'hFFFF_FFFE, 10, 32'd1, 32'hFFFF_FFFD);

        md_op   = 3'd5;
        rs_data = 32'h0000_1234;
        #1;
        check("mthi md_start", 32'(md_start), 32'd0);
        tick();
        md_op = 3'd0;
        check("mthi hi", hi, 32'h0000_1234);
        check("mthi lo", lo, 32'hFFFF_FFFD);
        check("mthi busy", 32'(busy), 32'd0);

        run_op("divu /0", 3'd4, 32'd99, 32'd0, 10, 32'h0000_1234, 32'hFFFF_FFFD);

        md_op   = 3'd6;
        rs_data = 32'h0000_0077;
        tick();
        md_op = 3'd0;
        check("mtlo lo", lo, 32'h0000_0077);
        check("mtlo hi", hi, 32'h0000_1234);

        // Flushed instructions must have no effect.
        md_op   = 3'd1;
        rs_data = 32'd3;
        rt_data = 32'd4;
        req     = 1'b1;
        #1;
        check("req md_start", 32'(md_start), 32'd0);
        tick();
        md_op   = 3'd5;
        rs_data = 32'hAAAA_AAAA;
        tick();
        md_op = 3'd0;
        req   = 1'b0;
        check("req busy", 32'(busy), 32'd0);
        check("req hi", hi, 32'h0000_1234);
        check("req lo", lo, 32'h0000_0077);

        // mult at T, mtlo at T+2 and a second mult at T+3 are both ignored.
        md_op   = 3'd1;
        rs_data = 32'd3;
        rt_data = 32'd4;
        tick();
        md_op = 3'd0;
        tick();
        md_op   = 3'd6;
        rs_data = 32'h0000_0055;
        tick();
        md_op   = 3'd1;
        rs_data = 32'd100;
        rt_data = 32'd100;
        #1;
        check("busy md_start", 32'(md_start), 32'd0);
        tick();
        md_op = 3'd0;
        check("busy lo held", lo, 32'h0000_0077);
        check("busy still", 32'(busy), 32'd1);
        tick();
        check("busy last", 32'(busy), 32'd1);
        tick();
        check("ovl busy done", 32'(busy), 32'd0);
        check("ovl hi", hi, 32'h0);
        check("ovl lo", lo, 32'd12);

        // req during RUN does not cancel the in-flight op.
        md_op   = 3'd2;
        rs_data = 32'd10;
        rt_data = 32'd10;
        tick();
        md_op = 3'd0;
        req   = 1'b1;
        tick();
        req = 1'b0;
        repeat (4) tick();
        check("req run busy", 32'(busy), 32'd0);
        check("req run lo", lo, 32'd100);

        // Reset in the middle of a div aborts it.
        md_op   = 3'd3;
        rs_data = 32'd100;
        rt_data = 32'd7;
        tick();
        md_op = 3'd0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("abort busy", 32'(busy), 32'd0);
        check("abort hi", hi, 32'h0);
        check("abort lo", lo, 32'h0);
        repeat (12) tick();
        check("no commit hi", hi, 32'h0);
        check("no commit lo", lo, 32'h0);
        check("no commit busy", 32'(busy), 32'd0);

        run_op("mult post", 3'd1, 32'd6, 32'd7, 5, 32'h0, 32'd42);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
